// File: rtl/seq_mon_pkg.sv
// Shared types and helpers for the hit monitor: FSM state encoding,
// default sizing constants and the saturating increment used by all counters.
package seq_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      ALARM = 2'b10
   } state_t;

   localparam int unsigned DEF_CNT_W   = 8;
   localparam int unsigned DEF_WIN_LEN = 64;

   // Returns v+1 when inc is set and v is below max_v, otherwise v unchanged.
   function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                           input logic        inc,
                                           input logic [31:0] max_v);
      if (inc && (v < max_v)) return v + 32'd1;
      return v;
   endfunction

endpackage

// File: rtl/seq_win_timer.sv
// Modulo-WIN_LEN cycle timer with enable and synchronous clear.
// last_cycle flags the final cycle of each window.
module seq_win_timer #(
   parameter  int unsigned WIN_LEN = 64,
   localparam int unsigned WIN_W   = $clog2(WIN_LEN)
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic last_cycle
);

   logic [WIN_W-1:0] timer;

   assign last_cycle = (timer == WIN_W'(WIN_LEN - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer <= '0;
      end else if (clr) begin
         timer <= '0;
      end else if (en) begin
         timer <= last_cycle ? '0 : timer + WIN_W'(1);
      end
   end

endmodule

// File: rtl/seq_hit_monitor.sv
// Windowed hit counter for the 1100 detector output: per-window count,
// last completed window count, saturating lifetime total and a sticky alarm.
module seq_hit_monitor
   import seq_mon_pkg::*;
#(
   parameter  int unsigned CNT_W   = DEF_CNT_W,
   parameter  int unsigned WIN_LEN = DEF_WIN_LEN,
   localparam int unsigned WIN_W   = $clog2(WIN_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hit_i,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] thresh,
   input  logic             alarm_ack,
   output logic [CNT_W-1:0] win_cnt,
   output logic [CNT_W-1:0] last_win_cnt,
   output logic [CNT_W-1:0] total_cnt,
   output logic             win_done,
   output logic             alarm
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   state_t           state;
   logic             counting;
   logic             last_cycle;
   logic             win_end;
   logic             trigger;
   logic [CNT_W-1:0] win_nxt;
   logic [CNT_W-1:0] total_nxt;

   assign counting = (state == RUN) || (state == ALARM);

   // Timer only runs in counting states with en high; anything else parks it at 0.
   seq_win_timer #(.WIN_LEN(WIN_LEN)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .en         (counting),
      .clr        (clr || !en || !counting),
      .last_cycle (last_cycle)
   );

   always_comb begin
      win_nxt   = CNT_W'(sat_inc(32'(win_cnt), hit_i, CNT_MAX));
      total_nxt = CNT_W'(sat_inc(32'(total_cnt), hit_i, CNT_MAX));
      win_end   = counting && last_cycle;
      // A hit on the last cycle is folded into the ending window before comparing.
      trigger   = win_end && (thresh != '0) && (win_nxt >= thresh);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         alarm        <= 1'b0;
         win_cnt      <= '0;
         last_win_cnt <= '0;
         total_cnt    <= '0;
         win_done     <= 1'b0;
      end else begin
         win_done <= 1'b0;
         if (clr) begin
            win_cnt      <= '0;
            last_win_cnt <= '0;
            total_cnt    <= '0;
            state        <= en ? RUN : IDLE;
            alarm        <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (en) state <= RUN;
               end
               RUN, ALARM: begin
                  if (!en) begin
                     state   <= IDLE;
                     alarm   <= 1'b0;
                     win_cnt <= '0;
                  end else begin
                     total_cnt <= total_nxt;
                     if (win_end) begin
                        last_win_cnt <= win_nxt;
                        win_cnt      <= '0;
                        win_done     <= 1'b1;
                     end else begin
                        win_cnt <= win_nxt;
                     end
                     // A fresh trigger outranks an acknowledge in the same cycle.
                     if (trigger) begin
                        state <= ALARM;
                        alarm <= 1'b1;
                     end else if ((state == ALARM) && alarm_ack) begin
                        state <= RUN;
                        alarm <= 1'b0;
                     end
                  end
               end
               default: begin
                  state   <= IDLE;
                  alarm   <= 1'b0;
                  win_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Directed bench for seq_hit_monitor with WIN_LEN=8; a second CNT_W=4
// instance exercises counter saturation.
module tb_seq_hit_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       hit, en, clr, ack;
   logic [7:0] thresh;
   logic [7:0] w, lw, tc;
   logic       wd, al;

   logic       hit4, en4, clr4, ack4;
   logic [3:0] thresh4;
   logic [3:0] w4, lw4, tc4;
   logic       wd4, al4;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   seq_hit_monitor #(.CNT_W(8), .WIN_LEN(8)) dut (
      .clk(clk), .rst(rst), .hit_i(hit), .en(en), .clr(clr), .thresh(thresh),
      .alarm_ack(ack), .win_cnt(w), .last_win_cnt(lw), .total_cnt(tc),
      .win_done(wd), .alarm(al)
   );

   seq_hit_monitor #(.CNT_W(4), .WIN_LEN(8)) dut4 (
      .clk(clk), .rst(rst), .hit_i(hit4), .en(en4), .clr(clr4), .thresh(thresh4),
      .alarm_ack(ack4), .win_cnt(w4), .last_win_cnt(lw4), .total_cnt(tc4),
      .win_done(wd4), .alarm(al4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Synchronous clear with en high: RUN, timer 0, all counters 0.
   task automatic start_run();
      clr = 1'b1; en = 1'b1; hit = 1'b0; ack = 1'b0;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      vectors++; if (w !== 8'd0) begin miscompares++; $display("FAIL reset_win_cnt got %0d want 0", w); end
      vectors++; if (lw !== 8'd0) begin miscompares++; $display("FAIL reset_last_win_cnt got %0d want 0", lw); end
      vectors++; if (tc !== 8'd0) begin miscompares++; $display("FAIL reset_total_cnt got %0d want 0", tc); end
      vectors++; if (wd !== 1'b0) begin miscompares++; $display("FAIL reset_win_done got %0b want 0", wd); end
      vectors++; if (al !== 1'b0) begin miscompares++; $display("FAIL reset_alarm got %0b want 0", al); end
      rst = 1'b1;
      tick();
      en = 1'b1;
      tick();
      hit = 1'b1;
      repeat (3) tick();
      hit = 1'b0;
      vectors++; if (w !== 8'd3) begin miscompares++; $display("FAIL pre_reset_win_cnt got %0d want 3", w); end
      #2 rst = 1'b0;
      #1;
      vectors++; if (w !== 8'd0) begin miscompares++; $display("FAIL async_reset_win_cnt got %0d want 0", w); end
      vectors++; if (tc !== 8'd0) begin miscompares++; $display("FAIL async_reset_total_cnt got %0d want 0", tc); end
      vectors++; if (al !== 1'b0) begin miscompares++; $display("FAIL async_reset_alarm got %0b want 0", al); end
      hit = 1'b1; en = 1'b1;
      rst = 1'b1;
      tick();
      vectors++; if (w !== 8'd0) begin miscompares++; $display("FAIL idle_after_release got %0d want 0", w); end
      tick();
      vectors++; if (w !== 8'd1) begin miscompares++; $display("FAIL first_run_count got %0d want 1", w); end
      hit = 1'b0; en = 1'b0;
      tick();
   endtask

   task automatic test_window();
      thresh = 8'd3;
      start_run();
      for (int c = 0; c < 8; c++) begin
         hit = (c == 1) || (c == 4) || (c == 7);
         tick();
         if (c == 6) begin
            vectors++; if (w !== 8'd2) begin miscompares++; $display("FAIL window_mid_cnt got %0d want 2", w); end
            vectors++; if (wd !== 1'b0) begin miscompares++; $display("FAIL window_early_done got %0b want 0", wd); end
         end
      end
      hit = 1'b0;
      vectors++; if (wd !== 1'b1) begin miscompares++; $display("FAIL window_done got %0b want 1", wd); end
      vectors++; if (lw !== 8'd3) begin miscompares++; $display("FAIL window_last_cnt got %0d want 3", lw); end
      vectors++; if (al !== 1'b1) begin miscompares++; $display("FAIL window_alarm got %0b want 1", al); end
      vectors++; if (w !== 8'd0) begin miscompares++; $display("FAIL window_cnt_cleared got %0d want 0", w); end
      tick();
      vectors++; if (wd !== 1'b0) begin miscompares++; $display("FAIL window_done_pulse got %0b want 0", wd); end
      vectors++; if (al !== 1'b1) begin miscompares++; $display("FAIL window_alarm_sticky got %0b want 1", al); end
   endtask

   task automatic test_below_thresh();
      thresh = 8'd4;
      start_run();
      for (int win = 0; win < 2; win++) begin
         for (int c = 0; c < 8; c++) begin
            hit = (c == 0) || (c == 3) || (c == 5);
            tick();
         end
         vectors++; if (lw !== 8'd3) begin miscompares++; $display("FAIL below_last_cnt win %0d got %0d want 3", win, lw); end
         vectors++; if (al !== 1'b0) begin miscompares++; $display("FAIL below_alarm win %0d got %0b want 0", win, al); end
      end
      hit = 1'b0;
      vectors++; if (tc !== 8'd6) begin miscompares++; $display("FAIL below_total got %0d want 6", tc); end
   endtask

   task automatic test_saturation();
      en4 = 1'b1; hit4 = 1'b1;
      tick();
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 4) begin
            vectors++; if (w4 !== 4'd4) begin miscompares++; $display("FAIL sat_win_cnt got %0d want 4", w4); end
         end
         if (i == 8) begin
            vectors++; if (lw4 !== 4'd8) begin miscompares++; $display("FAIL sat_first_window got %0d want 8", lw4); end
         end
         if (i == 15 || i == 16) begin
            vectors++; if (tc4 !== 4'd15) begin miscompares++; $display("FAIL sat_total at %0d got %0d want 15", i, tc4); end
         end
      end
      vectors++; if (tc4 !== 4'd15) begin miscompares++; $display("FAIL sat_total_end got %0d want 15", tc4); end
      vectors++; if (lw4 !== 4'd8) begin miscompares++; $display("FAIL sat_last_window got %0d want 8", lw4); end
      vectors++; if (wd4 !== 1'b1) begin miscompares++; $display("FAIL sat_win_done got %0b want 1", wd4); end
      vectors++; if (al4 !== 1'b0) begin miscompares++; $display("FAIL sat_alarm got %0b want 0", al4); end
      en4 = 1'b0; hit4 = 1'b0;
      tick();
   endtask

   task automatic test_ack_collision();
      thresh = 8'd2;
      start_run();
      for (int c = 0; c < 8; c++) begin
         hit = (c == 0) || (c == 1);
         tick();
      end
      vectors++; if (al !== 1'b1) begin miscompares++; $display("FAIL ack_setup_alarm got %0b want 1", al); end
      for (int c = 0; c < 8; c++) begin
         hit = (c == 2) || (c == 7);
         ack = (c == 7);
         tick();
         if (c == 3) begin
            vectors++; if (al !== 1'b1) begin miscompares++; $display("FAIL ack_alarm_held got %0b want 1", al); end
         end
      end
      vectors++; if (al !== 1'b1) begin miscompares++; $display("FAIL ack_collision_alarm got %0b want 1", al); end
      vectors++; if (lw !== 8'd2) begin miscompares++; $display("FAIL ack_collision_last got %0d want 2", lw); end
      hit = 1'b0; ack = 1'b1;
      tick();
      ack = 1'b0;
      vectors++; if (al !== 1'b0) begin miscompares++; $display("FAIL ack_clears_alarm got %0b want 0", al); end
   endtask

   task automatic test_clr();
      thresh = 8'd1;
      start_run();
      hit = 1'b1;
      repeat (8) tick();
      vectors++; if (al !== 1'b1) begin miscompares++; $display("FAIL clr_setup_alarm got %0b want 1", al); end
      vectors++; if (lw !== 8'd8) begin miscompares++; $display("FAIL clr_setup_last got %0d want 8", lw); end
      repeat (3) tick();
      vectors++; if (tc !== 8'd11) begin miscompares++; $display("FAIL clr_setup_total got %0d want 11", tc); end
      clr = 1'b1; en = 1'b1; hit = 1'b1;
      tick();
      clr = 1'b0;
      vectors++; if (w !== 8'd0) begin miscompares++; $display("FAIL clr_win_cnt got %0d want 0", w); end
      vectors++; if (tc !== 8'd0) begin miscompares++; $display("FAIL clr_total got %0d want 0", tc); end
      vectors++; if (lw !== 8'd0) begin miscompares++; $display("FAIL clr_last got %0d want 0", lw); end
      vectors++; if (al !== 1'b0) begin miscompares++; $display("FAIL clr_alarm got %0b want 0", al); end
      tick();
      hit = 1'b0;
      vectors++; if (w !== 8'd1) begin miscompares++; $display("FAIL clr_next_hit got %0d want 1", w); end
      vectors++; if (tc !== 8'd1) begin miscompares++; $display("FAIL clr_next_total got %0d want 1", tc); end
   endtask

   task automatic test_disable();
      thresh = 8'd0;
      start_run();
      hit = 1'b1;
      repeat (2) tick();
      en = 1'b0;
      tick();
      vectors++; if (w !== 8'd0) begin miscompares++; $display("FAIL disable_win_cnt got %0d want 0", w); end
      vectors++; if (tc !== 8'd2) begin miscompares++; $display("FAIL disable_total_kept got %0d want 2", tc); end
      tick();
      vectors++; if (tc !== 8'd2) begin miscompares++; $display("FAIL idle_ignores_hit got %0d want 2", tc); end
      en = 1'b1;
      tick();
      vectors++; if (w !== 8'd0) begin miscompares++; $display("FAIL reenable_first got %0d want 0", w); end
      tick();
      hit = 1'b0;
      vectors++; if (w !== 8'd1) begin miscompares++; $display("FAIL reenable_count got %0d want 1", w); end
   endtask

   initial begin
      rst = 1'b0; hit = 1'b0; en = 1'b0; clr = 1'b0; ack = 1'b0; thresh = 8'd0;
      hit4 = 1'b0; en4 = 1'b0; clr4 = 1'b0; ack4 = 1'b0; thresh4 = 4'd0;
      repeat (2) tick();
      test_reset();
      test_window();
      test_below_thresh();
      test_saturation();
      test_ack_collision();
      test_clr();
      test_disable();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
